mm_cmd_arbiter: RTL and testbench

MM_CMD_ARBITER -- requirements
Module: mm_cmd_arbiter

---
 rtl/mm_pkg.sv | 41 ++++
 rtl/mm_rr_arbiter.sv | 41 ++++
 rtl/mm_cmd_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mm_cmd_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// ---------------------------------------------------------------------------
// mm_pkg
// Definitions shared by the management-module command arbiter:
//   - mmState_t : command FSM state encoding
//   - OP_*      : management-module operational state codes (mm_op_state)
//   - TPM_CC_*  : TPM command codes issued through the arbiter
//   - TPM_RC_*  : TPM response codes returned by the management module
//   - rrNext()  : round-robin pointer increment with wrap
// ---------------------------------------------------------------------------
package mm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4
  } mmState_t;

  localparam logic [2:0] OP_POWER_OFF      = 3'b000;
  localparam logic [2:0] OP_INITIALIZATION = 3'b001;
  localparam logic [2:0] OP_STARTUP        = 3'b010;
  localparam logic [2:0] OP_OPERATIONAL    = 3'b011;
  localparam logic [2:0] OP_SELF_TEST      = 3'b100;
  localparam logic [2:0] OP_FAILURE        = 3'b101;
  localparam logic [2:0] OP_SHUTDOWN       = 3'b110;

  localparam logic [31:0] TPM_CC_SELFTEST = 32'h0000_0143;
  localparam logic [31:0] TPM_CC_STARTUP  = 32'h0000_0144;
  localparam logic [31:0] TPM_CC_SHUTDOWN = 32'h0000_0145;

  localparam logic [31:0] TPM_RC_SUCCESS    = 32'h0000_0000;
  localparam logic [31:0] TPM_RC_INITIALIZE = 32'h0000_0100;
  localparam logic [31:0] TPM_RC_FAILURE    = 32'h0000_0101;

  // Next round-robin start position after granting idx, wrapping at n.
  function automatic int rrNext(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mm_rr_arbiter
// Combinational round-robin selector. Searches req starting at rrPtr and
// wrapping, and returns the first set requester.
// Ports:
//   req      in  NUM_REQ : request vector
//   rrPtr    in  IDXW    : index searched first
//   grant    out NUM_REQ : one-hot grant (all zero when req is zero)
//   grantIdx out IDXW    : index of the granted requester
// ---------------------------------------------------------------------------
module mm_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    rrPtr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    grantIdx
);

  // NOTE: every output gets a default before the search loop; otherwise a
  // path with no winner would leave it unassigned and infer a latch.
  always_comb begin
    logic found;
    int   idx;
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rrPtr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grantIdx   = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/mm_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// mm_cmd_arbiter
// Arbitrates TPM commands from NUM_REQ requesters onto a single management
// module command port. One command is in flight at a time:
//   IDLE -> LOAD -> START (keyStart low) -> WAIT -> CAPTURE (done) -> IDLE
// Requester index i is TPM locality i.
//
// Parameters:
//   NUM_REQ   : number of requesters
//   RESP_WAIT : wait-counter terminal count before capture (legal 1..15)
// Ports:
//   clock, reset_n             : clock, async active-low reset
//   req        in  NUM_REQ     : level requests, held until done
//   req_cc     in  NUM_REQ*32  : per-requester command code
//   req_param  in  NUM_REQ*33  : per-requester command parameters
//   done       out NUM_REQ     : one-cycle completion pulse to the grantee
//   rsp_rc     out 32          : captured response code (held)
//   busy       out 1           : high whenever not IDLE
//   mm_keyStart_n out 1        : active-low start strobe
//   mm_tpm_cc  out 32          : command code to management module
//   mm_cmd_param out 33        : command parameters to management module
//   mm_locality out 8          : locality of the granted requester
//   mm_tpm_rc  in  32          : response code from management module
//   mm_op_state in 3           : management module operational state
//
// Build option: MM_ARB_LOC4_PRIORITY_EN -- with NUM_REQ >= 5, requester 4
// preempts round-robin whenever it requests, and its grants do not move the
// round-robin pointer.
// ---------------------------------------------------------------------------
module mm_cmd_arbiter
  import mm_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int RESP_WAIT = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] req_cc,
  input  logic [NUM_REQ*33-1:0] req_param,
  output logic [NUM_REQ-1:0]    done,
  output logic [31:0]           rsp_rc,
  output logic                  busy,
  output logic                  mm_keyStart_n,
  output logic [31:0]           mm_tpm_cc,
  output logic [32:0]           mm_cmd_param,
  output logic [7:0]            mm_locality,
  input  logic [31:0]           mm_tpm_rc,
  input  logic [2:0]            mm_op_state
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  mmState_t           state;
  logic [IDXW-1:0]    rrPtr;
  logic [3:0]         waitCnt;
  logic [31:0]        latCc;
  logic [32:0]        latParam;
  logic [IDXW-1:0]    latIdx;
  logic [NUM_REQ-1:0] latGrant;

  logic [NUM_REQ-1:0] arbGrant;
  logic [IDXW-1:0]    arbIdx;
  logic               loc4Req;
  logic [NUM_REQ-1:0] selGrant;
  logic [IDXW-1:0]    selIdx;

  mm_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_rr (
    .req      (req),
    .rrPtr    (rrPtr),
    .grant    (arbGrant),
    .grantIdx (arbIdx)
  );

`ifdef MM_ARB_LOC4_PRIORITY_EN
  if (NUM_REQ >= 5) begin : g_loc4
    assign loc4Req = req[4];
  end else begin : g_noLoc4
    assign loc4Req = 1'b0;
  end
`else
  assign loc4Req = 1'b0;
`endif

  // Locality 4 override sits in front of the round-robin result.
  always_comb begin
    selGrant = arbGrant;
    selIdx   = arbIdx;
    if (loc4Req) begin
      selGrant = NUM_REQ'(1) << 4;
      selIdx   = IDXW'(4);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  // NOTE: the latched command registers are reset as well, so nothing in the
  // datapath is ever X after reset even though they are rewritten per grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      rrPtr         <= '0;
      waitCnt       <= '0;
      latCc         <= '0;
      latParam      <= '0;
      latIdx        <= '0;
      latGrant      <= '0;
      done          <= '0;
      busy          <= 1'b0;
      mm_keyStart_n <= 1'b1;
      mm_tpm_cc     <= '0;
      mm_cmd_param  <= '0;
      mm_locality   <= '0;
      rsp_rc        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= '0;
          if (|req) begin
            latCc    <= req_cc[int'(selIdx)*32 +: 32];
            latParam <= req_param[int'(selIdx)*33 +: 33];
            latIdx   <= selIdx;
            latGrant <= selGrant;
            if (!loc4Req) rrPtr <= IDXW'(rrNext(int'(selIdx), NUM_REQ));
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          mm_tpm_cc    <= latCc;
          mm_cmd_param <= latParam;
          mm_locality  <= 8'(latIdx);
          state        <= ST_START;
        end
        ST_START: begin
          mm_keyStart_n <= 1'b0;
          waitCnt       <= '0;
          state         <= ST_WAIT;
        end
        ST_WAIT: begin
          mm_keyStart_n <= 1'b1;
          // Terminal count lands the capture so done appears RESP_WAIT+3
          // cycles after the grant edge.
          if (waitCnt == 4'(RESP_WAIT)) begin
            rsp_rc <= mm_tpm_rc;
            done   <= latGrant;
            state  <= ST_CAPTURE;
          end else begin
            waitCnt <= waitCnt + 4'd1;
          end
        end
        ST_CAPTURE: begin
          done    <= '0;
          busy    <= 1'b0;
          waitCnt <= '0;
          state   <= ST_IDLE;
        end
        default: begin
          done          <= '0;
          busy          <= 1'b0;
          mm_keyStart_n <= 1'b1;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

  // The management module only reports the seven defined operational states;
  // commands are issued in every one of them, including failure mode.
  opStateLegal: assert property (@(posedge clock) disable iff (!reset_n)
                                 mm_op_state <= OP_SHUTDOWN);

endmodule

// File: tb/tb_mm_cmd_arbiter.sv
module tb_mm_cmd_arbiter;
  import mm_pkg::*;

`ifdef MM_ARB_LOC4_PRIORITY_EN
  localparam int N = 5;
`else
  localparam int N = 4;
`endif

  logic            clock;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*32-1:0] req_cc;
  logic [N*33-1:0] req_param;
  logic [N-1:0]    done;
  logic [31:0]     rsp_rc;
  logic            busy;
  logic            mm_keyStart_n;
  logic [31:0]     mm_tpm_cc;
  logic [32:0]     mm_cmd_param;
  logic [7:0]      mm_locality;
  logic [31:0]     mm_tpm_rc;
  logic [2:0]      mm_op_state;

  int testsRun    = 0;
  int testsFailed = 0;

  mm_cmd_arbiter #(.NUM_REQ(N), .RESP_WAIT(2)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req           (req),
    .req_cc        (req_cc),
    .req_param     (req_param),
    .done          (done),
    .rsp_rc        (rsp_rc),
    .busy          (busy),
    .mm_keyStart_n (mm_keyStart_n),
    .mm_tpm_cc     (mm_tpm_cc),
    .mm_cmd_param  (mm_cmd_param),
    .mm_locality   (mm_locality),
    .mm_tpm_rc     (mm_tpm_rc),
    .mm_op_state   (mm_op_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setCmd(input int i, input logic [31:0] cc, input logic [32:0] prm);
    req_cc[i*32 +: 32]    = cc;
    req_param[i*33 +: 33] = prm;
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    req     = '0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  // Steps cycles until a done pulse is seen (bounded), returns the vector.
  task automatic waitDone(output logic [N-1:0] d);
    d = '0;
    for (int k = 0; k < 20 && d == '0; k++) begin
      tick();
      d = done;
    end
    check("done_seen", (d != '0), 1);
  endtask

  logic [N-1:0] d;
  logic         sawDone;
  logic         sawStrobe;

  initial begin
    reset_n     = 1'b0;
    req         = '0;
    req_cc      = '0;
    req_param   = '0;
    mm_tpm_rc   = TPM_RC_SUCCESS;
    mm_op_state = OP_OPERATIONAL;

    // Reset state
    applyReset();
    check("rst_busy", busy, 0);
    check("rst_strobe", mm_keyStart_n, 1);
    check("rst_done", done, 0);
    check("rst_cc", mm_tpm_cc, 0);
    check("rst_loc", mm_locality, 0);
    check("rst_rc", rsp_rc, 0);

    // Single command, exact latency
    setCmd(0, TPM_CC_STARTUP, 33'h0);
    req = N'(1);
    tick();                                   // t: grant
    check("t0_busy", busy, 1);
    check("t0_strobe", mm_keyStart_n, 1);
    tick();                                   // t+1: LOAD done
    check("t1_cc", mm_tpm_cc, TPM_CC_STARTUP);
    check("t1_strobe", mm_keyStart_n, 1);
    tick();                                   // t+2
    check("t2_strobe", mm_keyStart_n, 0);
    tick();                                   // t+3
    check("t3_strobe", mm_keyStart_n, 1);
    check("t3_done", done, 0);
    tick();                                   // t+4
    check("t4_done", done, 0);
    tick();                                   // t+5
    check("t5_done", done, 1);
    check("t5_rc", rsp_rc, TPM_RC_SUCCESS);
    req = '0;
    tick();                                   // t+6
    check("t6_done", done, 0);
    check("t6_busy", busy, 0);
    repeat (3) tick();
    check("idle_cc_hold", mm_tpm_cc, TPM_CC_STARTUP);
    check("idle_strobe", mm_keyStart_n, 1);

    // Continuous 1111: 0,1,2,3,0
    applyReset();
    for (int i = 0; i < 4; i++) setCmd(i, 32'h200 + i, 33'(i));
    req = N'(4'hF);
    for (int k = 0; k < 5; k++) begin
      waitDone(d);
      check("rr_done", d, 1 << (k % 4));
      check("rr_loc", mm_locality, k % 4);
      check("rr_cc", mm_tpm_cc, 32'h200 + (k % 4));
      tick();
      check("rr_single_pulse", done, 0);
    end
    req = '0;
    repeat (10) tick();

    // Pointer at 3 then 1001: 3 first, then wrap to 0
    applyReset();
    req = N'(4'b0100);
    waitDone(d);
    check("ptr_setup", d, 4'b0100);
    req = '0;
    tick();
    req = N'(4'b1001);
    waitDone(d);
    check("wrap_first", d, 4'b1000);
    check("wrap_first_loc", mm_locality, 3);
    req = N'(4'b0001);
    waitDone(d);
    check("wrap_second", d, 4'b0001);
    check("wrap_second_loc", mm_locality, 0);
    req = '0;
    repeat (3) tick();

    // Failure mode: rc returned unmodified
    mm_op_state = OP_FAILURE;
    mm_tpm_rc   = TPM_RC_FAILURE;
    setCmd(1, TPM_CC_SHUTDOWN, 33'h1_2345_6789);
    req = N'(4'b0010);
    waitDone(d);
    check("fail_done", d, 4'b0010);
    check("fail_rc", rsp_rc, TPM_RC_FAILURE);
    check("fail_cc", mm_tpm_cc, TPM_CC_SHUTDOWN);
    check("fail_param", mm_cmd_param, 33'h1_2345_6789);
    req = '0;
    repeat (3) tick();

    // Reset during WAIT abandons the command
    mm_op_state = OP_OPERATIONAL;
    req = N'(1);
    sawStrobe = 1'b0;
    for (int k = 0; k < 10 && !sawStrobe; k++) begin
      tick();
      sawStrobe = !mm_keyStart_n;
    end
    check("rw_strobe_seen", sawStrobe, 1);
    tick();                                   // now in WAIT
    #2;
    reset_n = 1'b0;
    #1;
    check("rw_strobe", mm_keyStart_n, 1);
    check("rw_busy", busy, 0);
    check("rw_done", done, 0);
    check("rw_cc", mm_tpm_cc, 0);
    check("rw_param", mm_cmd_param, 0);
    check("rw_rc", rsp_rc, 0);
    req = '0;
    sawDone = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done != '0) sawDone = 1'b1;
    end
    check("rw_no_done", sawDone, 0);
    reset_n   = 1'b1;
    mm_tpm_rc = TPM_RC_INITIALIZE;
    req = N'(4'b0010);
    tick();                                   // grant
    tick();
    req = '0;                                 // drop after grant
    waitDone(d);
    check("post_rst_done", d, 4'b0010);
    check("post_rst_rc", rsp_rc, TPM_RC_INITIALIZE);
    check("post_rst_loc", mm_locality, 1);
    repeat (3) tick();

`ifdef MM_ARB_LOC4_PRIORITY_EN
    // Locality 4 priority
    applyReset();
    setCmd(4, TPM_CC_SELFTEST, 33'h4);
    req = 5'b11111;
    for (int k = 0; k < 3; k++) begin
      waitDone(d);
      check("loc4_done", d, 5'b10000);
      check("loc4_loc", mm_locality, 4);
    end
    req = 5'b01111;
    waitDone(d);
    check("loc4_ptr_kept", d, 5'b00001);
    req = '0;
    repeat (3) tick();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
